// File: rtl/mem_bus_arbiter.sv
// Round-robin req/ack arbiter sharing one data memory between CPU and I/O.
// Ports: clk/reset, cpu_* and io_* requester sides, mem_* memory side, busy, owner.
module mem_bus_arbiter #(
  parameter int AW       = 10,
  parameter int DW       = 16,
  parameter int MEM_LAT  = 1,
  parameter int CPU_PRIO = 0
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          cpu_req,
  input  logic          cpu_we,
  input  logic [AW-1:0] cpu_addr,
  input  logic [DW-1:0] cpu_wdata,
  output logic          cpu_ack,
  output logic [DW-1:0] cpu_rdata,
  input  logic          io_req,
  input  logic          io_we,
  input  logic [AW-1:0] io_addr,
  input  logic [DW-1:0] io_wdata,
  output logic          io_ack,
  output logic [DW-1:0] io_rdata,
  output logic          mem_en,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_ACCESS = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_ACK    = 2'd3;

  localparam logic [1:0] LAT_M1 = 2'(MEM_LAT - 1);
  localparam logic       PRIO   = (CPU_PRIO != 0);

  logic [1:0]    state_q, state_d;
  logic [1:0]    cnt_q, cnt_d;
  logic          we_q, we_d;
  logic [AW-1:0] addr_q, addr_d;
  logic [DW-1:0] wdata_q, wdata_d;
  logic          owner_q, owner_d;
  logic          last_q, last_d;
  logic [DW-1:0] crd_q, crd_d;
  logic [DW-1:0] ird_q, ird_d;
  logic          pick_io;

  // IO wins when alone, or on a tie when round-robin says CPU went last.
  assign pick_io = io_req & (~cpu_req | (~PRIO & ~last_q));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    owner_d = owner_q;
    last_d  = last_q;
    crd_d   = crd_q;
    ird_d   = ird_q;
    unique case (state_q)
      S_IDLE: begin
        if (cpu_req | io_req) begin
          state_d = S_ACCESS;
          owner_d = pick_io;
          last_d  = pick_io;
          we_d    = pick_io ? io_we    : cpu_we;
          addr_d  = pick_io ? io_addr  : cpu_addr;
          wdata_d = pick_io ? io_wdata : cpu_wdata;
        end
      end
      S_ACCESS: begin
        state_d = S_WAIT;
        cnt_d   = LAT_M1;
      end
      S_WAIT: begin
        if (cnt_q == 2'd0) begin
          state_d = S_ACK;
          if (!we_q) begin
            if (owner_q) ird_d = mem_rdata;
            else         crd_d = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 2'd1;
        end
      end
      S_ACK: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 2'd0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      owner_q <= 1'b0;
      last_q  <= 1'b1;
      crd_q   <= '0;
      ird_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      owner_q <= owner_d;
      last_q  <= last_d;
      crd_q   <= crd_d;
      ird_q   <= ird_d;
    end
  end

  assign mem_en    = (state_q == S_ACCESS);
  assign mem_we    = mem_en & we_q;
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign busy      = (state_q != S_IDLE);
  assign owner     = owner_q;
  assign cpu_ack   = (state_q == S_ACK) & ~owner_q;
  assign io_ack    = (state_q == S_ACK) & owner_q;
  assign cpu_rdata = crd_q;
  assign io_rdata  = ird_q;

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Directed self-checking bench for mem_bus_arbiter.
// Three instances: LAT1/round-robin, LAT1/CPU priority, LAT3/round-robin.
module tb_mem_bus_arbiter;

  logic clk;
  logic reset;

  logic        cpu_req   [3];
  logic        cpu_we    [3];
  logic [9:0]  cpu_addr  [3];
  logic [15:0] cpu_wdata [3];
  logic        cpu_ack   [3];
  logic [15:0] cpu_rdata [3];
  logic        io_req    [3];
  logic        io_we     [3];
  logic [9:0]  io_addr   [3];
  logic [15:0] io_wdata  [3];
  logic        io_ack    [3];
  logic [15:0] io_rdata  [3];
  logic        mem_en    [3];
  logic        mem_we    [3];
  logic [9:0]  mem_addr  [3];
  logic [15:0] mem_wdata [3];
  logic [15:0] mem_rdata [3];
  logic        busy      [3];
  logic        owner     [3];

  logic [2:0]  pl_en;
  logic [9:0]  pl_addr;
  logic [15:0] pl_data;

  int checks;
  int errors;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : gi
    localparam int LAT = (g == 2) ? 3 : 1;
    localparam int PR  = (g == 1) ? 1 : 0;
    logic [15:0] mem [1024];

    mem_bus_arbiter #(
      .AW(10), .DW(16), .MEM_LAT(LAT), .CPU_PRIO(PR)
    ) u_dut (
      .clk(clk), .reset(reset),
      .cpu_req(cpu_req[g]), .cpu_we(cpu_we[g]),
      .cpu_addr(cpu_addr[g]), .cpu_wdata(cpu_wdata[g]),
      .cpu_ack(cpu_ack[g]), .cpu_rdata(cpu_rdata[g]),
      .io_req(io_req[g]), .io_we(io_we[g]),
      .io_addr(io_addr[g]), .io_wdata(io_wdata[g]),
      .io_ack(io_ack[g]), .io_rdata(io_rdata[g]),
      .mem_en(mem_en[g]), .mem_we(mem_we[g]),
      .mem_addr(mem_addr[g]), .mem_wdata(mem_wdata[g]),
      .mem_rdata(mem_rdata[g]),
      .busy(busy[g]), .owner(owner[g])
    );

    assign mem_rdata[g] = mem[mem_addr[g]];

    always @(posedge clk) begin
      if (pl_en[g]) mem[pl_addr] <= pl_data;
      else if (mem_en[g] && mem_we[g]) mem[mem_addr[g]] <= mem_wdata[g];
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic preload(input int k, input logic [9:0] a,
                         input logic [15:0] d);
    pl_en   = 3'b000;
    pl_en[k] = 1'b1;
    pl_addr = a;
    pl_data = d;
    step();
    pl_en = 3'b000;
  endtask

  task automatic test_reset();
    for (int k = 0; k < 3; k++) begin
      checks++;
      if (mem_en[k] !== 1'b0 || busy[k] !== 1'b0 || owner[k] !== 1'b0) begin
        errors++;
        $display("FAIL rst_ctrl[%0d] got en=%b busy=%b own=%b exp 0 0 0",
                 k, mem_en[k], busy[k], owner[k]);
      end
      checks++;
      if (cpu_ack[k] !== 1'b0 || io_ack[k] !== 1'b0) begin
        errors++;
        $display("FAIL rst_ack[%0d] got %b %b exp 0 0", k, cpu_ack[k], io_ack[k]);
      end
      checks++;
      if (cpu_rdata[k] !== 16'h0 || io_rdata[k] !== 16'h0 ||
          mem_addr[k] !== 10'h0 || mem_wdata[k] !== 16'h0) begin
        errors++;
        $display("FAIL rst_data[%0d] got %h %h %h %h exp all 0", k,
                 cpu_rdata[k], io_rdata[k], mem_addr[k], mem_wdata[k]);
      end
    end
  endtask

  task automatic test_cpu_read();
    cpu_we[0] = 1'b0; cpu_addr[0] = 10'h010; cpu_req[0] = 1'b1;
    step();
    checks++;
    if (mem_en[0] !== 1'b1 || mem_we[0] !== 1'b0 || mem_addr[0] !== 10'h010) begin
      errors++;
      $display("FAIL t1_access got en=%b we=%b a=%h exp 1 0 010",
               mem_en[0], mem_we[0], mem_addr[0]);
    end
    checks++;
    if (busy[0] !== 1'b1 || owner[0] !== 1'b0) begin
      errors++;
      $display("FAIL t1_busy_owner got %b %b exp 1 0", busy[0], owner[0]);
    end
    step();
    checks++;
    if (mem_en[0] !== 1'b0 || cpu_ack[0] !== 1'b0) begin
      errors++;
      $display("FAIL t1_wait got en=%b ack=%b exp 0 0", mem_en[0], cpu_ack[0]);
    end
    step();
    checks++;
    if (cpu_ack[0] !== 1'b1 || io_ack[0] !== 1'b0) begin
      errors++;
      $display("FAIL t1_ack got cpu=%b io=%b exp 1 0", cpu_ack[0], io_ack[0]);
    end
    checks++;
    if (cpu_rdata[0] !== 16'hBEEF) begin
      errors++;
      $display("FAIL t1_rdata got %h exp beef", cpu_rdata[0]);
    end
    cpu_req[0] = 1'b0;
    step();
    checks++;
    if (cpu_ack[0] !== 1'b0 || busy[0] !== 1'b0) begin
      errors++;
      $display("FAIL t1_idle got ack=%b busy=%b exp 0 0", cpu_ack[0], busy[0]);
    end
  endtask

  task automatic test_io_write();
    io_we[0] = 1'b1; io_addr[0] = 10'h020; io_wdata[0] = 16'h1234;
    io_req[0] = 1'b1;
    step();
    checks++;
    if (mem_en[0] !== 1'b1 || mem_we[0] !== 1'b1 ||
        mem_addr[0] !== 10'h020 || mem_wdata[0] !== 16'h1234) begin
      errors++;
      $display("FAIL t2_access got en=%b we=%b a=%h d=%h exp 1 1 020 1234",
               mem_en[0], mem_we[0], mem_addr[0], mem_wdata[0]);
    end
    checks++;
    if (owner[0] !== 1'b1) begin
      errors++;
      $display("FAIL t2_owner got %b exp 1", owner[0]);
    end
    step();
    checks++;
    if (mem_we[0] !== 1'b0) begin
      errors++;
      $display("FAIL t2_we_once got %b exp 0", mem_we[0]);
    end
    step();
    checks++;
    if (io_ack[0] !== 1'b1 || cpu_ack[0] !== 1'b0 || io_rdata[0] !== 16'h0) begin
      errors++;
      $display("FAIL t2_ack got io=%b cpu=%b iord=%h exp 1 0 0000",
               io_ack[0], cpu_ack[0], io_rdata[0]);
    end
    io_req[0] = 1'b0;
    step();
    cpu_we[0] = 1'b0; cpu_addr[0] = 10'h020; cpu_req[0] = 1'b1;
    step(); step(); step();
    checks++;
    if (cpu_ack[0] !== 1'b1 || cpu_rdata[0] !== 16'h1234) begin
      errors++;
      $display("FAIL t2_readback got ack=%b d=%h exp 1 1234",
               cpu_ack[0], cpu_rdata[0]);
    end
    cpu_req[0] = 1'b0;
    step();
  endtask

  task automatic test_latch_fields();
    cpu_we[0] = 1'b1; cpu_addr[0] = 10'h050; cpu_wdata[0] = 16'hAAAA;
    cpu_req[0] = 1'b1;
    step();
    checks++;
    if (mem_en[0] !== 1'b1 || mem_we[0] !== 1'b1 ||
        mem_addr[0] !== 10'h050 || mem_wdata[0] !== 16'hAAAA) begin
      errors++;
      $display("FAIL t6_access got en=%b we=%b a=%h d=%h exp 1 1 050 aaaa",
               mem_en[0], mem_we[0], mem_addr[0], mem_wdata[0]);
    end
    step();
    cpu_addr[0] = 10'h060; cpu_wdata[0] = 16'h5555;
    #1;
    checks++;
    if (mem_addr[0] !== 10'h050 || mem_wdata[0] !== 16'hAAAA) begin
      errors++;
      $display("FAIL t6_wait_bus got a=%h d=%h exp 050 aaaa",
               mem_addr[0], mem_wdata[0]);
    end
    step();
    checks++;
    if (cpu_ack[0] !== 1'b1 || mem_addr[0] !== 10'h050 ||
        mem_wdata[0] !== 16'hAAAA) begin
      errors++;
      $display("FAIL t6_ack_bus got ack=%b a=%h d=%h exp 1 050 aaaa",
               cpu_ack[0], mem_addr[0], mem_wdata[0]);
    end
    checks++;
    if (cpu_rdata[0] !== 16'h1234) begin
      errors++;
      $display("FAIL t6_rdata_hold got %h exp 1234", cpu_rdata[0]);
    end
    cpu_req[0] = 1'b0;
    step();
    checks++;
    if (gi[0].mem[10'h050] !== 16'hAAAA || gi[0].mem[10'h060] !== 16'h0F0F) begin
      errors++;
      $display("FAIL t6_mem got [050]=%h [060]=%h exp aaaa 0f0f",
               gi[0].mem[10'h050], gi[0].mem[10'h060]);
    end
  endtask

  task automatic test_round_robin();
    reset = 1'b1;
    step();
    reset = 1'b0;
    cpu_we[0] = 1'b0; cpu_addr[0] = 10'h030;
    io_we[0]  = 1'b0; io_addr[0]  = 10'h040;
    cpu_req[0] = 1'b1; io_req[0] = 1'b1;
    for (int i = 0; i < 4; i++) begin
      if (i == 0) begin step(); step(); step(); end
      else begin step(); step(); step(); step(); end
      checks++;
      if (cpu_ack[0] !== ((i % 2) == 0) || io_ack[0] !== ((i % 2) == 1)) begin
        errors++;
        $display("FAIL t3_grant%0d got cpu=%b io=%b exp %b %b", i,
                 cpu_ack[0], io_ack[0], (i % 2) == 0, (i % 2) == 1);
      end
      checks++;
      if (owner[0] !== ((i % 2) == 1)) begin
        errors++;
        $display("FAIL t3_owner%0d got %b exp %b", i, owner[0], (i % 2) == 1);
      end
    end
    checks++;
    if (cpu_rdata[0] !== 16'h1111 || io_rdata[0] !== 16'h2222) begin
      errors++;
      $display("FAIL t3_rdata got %h %h exp 1111 2222",
               cpu_rdata[0], io_rdata[0]);
    end
    cpu_req[0] = 1'b0; io_req[0] = 1'b0;
    step();
  endtask

  task automatic test_cpu_prio();
    cpu_we[1] = 1'b0; cpu_addr[1] = 10'h030;
    io_we[1]  = 1'b0; io_addr[1]  = 10'h040;
    cpu_req[1] = 1'b1; io_req[1] = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (i == 0) begin step(); step(); step(); end
      else begin step(); step(); step(); step(); end
      checks++;
      if (cpu_ack[1] !== 1'b1 || io_ack[1] !== 1'b0) begin
        errors++;
        $display("FAIL t4_cpu%0d got cpu=%b io=%b exp 1 0", i,
                 cpu_ack[1], io_ack[1]);
      end
    end
    cpu_req[1] = 1'b0;
    step(); step(); step(); step();
    checks++;
    if (io_ack[1] !== 1'b1 || cpu_ack[1] !== 1'b0 || io_rdata[1] !== 16'h4444) begin
      errors++;
      $display("FAIL t4_io got io=%b cpu=%b d=%h exp 1 0 4444",
               io_ack[1], cpu_ack[1], io_rdata[1]);
    end
    io_req[1] = 1'b0;
    step();
  endtask

  task automatic test_lat3_reset();
    io_we[2] = 1'b0; io_addr[2] = 10'h070; io_req[2] = 1'b1;
    step(); step(); step(); step();
    checks++;
    if (io_ack[2] !== 1'b0 || busy[2] !== 1'b1) begin
      errors++;
      $display("FAIL t5_early got ack=%b busy=%b exp 0 1", io_ack[2], busy[2]);
    end
    step();
    checks++;
    if (io_ack[2] !== 1'b1 || io_rdata[2] !== 16'h3C3C) begin
      errors++;
      $display("FAIL t5_ack got ack=%b d=%h exp 1 3c3c", io_ack[2], io_rdata[2]);
    end
    io_req[2] = 1'b0;
    step();
    io_addr[2] = 10'h074; io_req[2] = 1'b1;
    step(); step();
    reset = 1'b1;
    #1;
    checks++;
    if (busy[2] !== 1'b0 || mem_en[2] !== 1'b0 ||
        io_ack[2] !== 1'b0 || io_rdata[2] !== 16'h0) begin
      errors++;
      $display("FAIL t5_abort got busy=%b en=%b ack=%b d=%h exp 0 0 0 0000",
               busy[2], mem_en[2], io_ack[2], io_rdata[2]);
    end
    io_req[2] = 1'b0;
    step();
    checks++;
    if (io_ack[2] !== 1'b0 || busy[2] !== 1'b0) begin
      errors++;
      $display("FAIL t5_no_ack got ack=%b busy=%b exp 0 0", io_ack[2], busy[2]);
    end
    reset = 1'b0;
    io_req[2] = 1'b1;
    step(); step(); step(); step(); step();
    checks++;
    if (io_ack[2] !== 1'b1 || io_rdata[2] !== 16'h7777) begin
      errors++;
      $display("FAIL t5_fresh got ack=%b d=%h exp 1 7777", io_ack[2], io_rdata[2]);
    end
    io_req[2] = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

  initial begin
    checks = 0;
    errors = 0;
    reset = 1'b1;
    pl_en = 3'b000;
    pl_addr = '0;
    pl_data = '0;
    for (int k = 0; k < 3; k++) begin
      cpu_req[k] = 1'b0; cpu_we[k] = 1'b0;
      cpu_addr[k] = '0;  cpu_wdata[k] = '0;
      io_req[k] = 1'b0;  io_we[k] = 1'b0;
      io_addr[k] = '0;   io_wdata[k] = '0;
    end
    step();
    step();
    test_reset();
    preload(0, 10'h010, 16'hBEEF);
    preload(0, 10'h060, 16'h0F0F);
    preload(0, 10'h030, 16'h1111);
    preload(0, 10'h040, 16'h2222);
    preload(1, 10'h030, 16'h3333);
    preload(1, 10'h040, 16'h4444);
    preload(2, 10'h070, 16'h3C3C);
    preload(2, 10'h074, 16'h7777);
    reset = 1'b0;
    step();
    test_cpu_read();
    test_io_write();
    test_latch_fields();
    test_round_robin();
    test_cpu_prio();
    test_lat3_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
